// File: rtl/flex_pts_tx_if.sv
// flex_pts_tx_if: word-load handshake between a producer and flex_pts_tx.
// The producer drives the word and valid; the transmitter answers with ready.
interface flex_pts_tx_if #(
    parameter int NUM_BITS = 8
) ();
    logic                load_valid;
    logic                load_ready;
    logic [NUM_BITS-1:0] parallel_in;

    modport master (
        output load_valid,
        output parallel_in,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  parallel_in,
        output load_ready
    );
endinterface

// File: rtl/flex_pts_tx.sv
// flex_pts_tx: parallel-to-serial transmitter with a one-word holding buffer,
// per-word bit counter, word_done pulse, busy flag and configurable idle level.
module flex_pts_tx #(
    parameter int NUM_BITS  = 8,
    parameter bit SHIFT_MSB = 1'b1,
    parameter bit IDLE_VAL  = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         shift_enable,
    flex_pts_tx_if.slave ld,
    output logic         serial_out,
    output logic         busy,
    output logic         word_done
);
    localparam int            CW    = $clog2(NUM_BITS);
    localparam logic [CW-1:0] LAST  = CW'(NUM_BITS - 1);
    localparam logic [0:0]    IDLE  = 1'b0;
    localparam logic [0:0]    SHIFT = 1'b1;

    logic [0:0]          state;
    logic [NUM_BITS-1:0] buff;
    logic [NUM_BITS-1:0] hold;
    logic [NUM_BITS-1:0] shifted;
    logic [NUM_BITS-1:0] fill;
    logic                hold_full;
    logic [CW-1:0]       cnt;
    logic                accept;
    logic                final_shift;

    assign fill          = {NUM_BITS{IDLE_VAL}};
    assign ld.load_ready = !hold_full;
    assign accept        = ld.load_valid && !hold_full;
    assign final_shift   = (state == SHIFT) && shift_enable && (cnt == LAST);
    assign busy          = (state == SHIFT);

    // Next shift-register image: move toward the output end, back-fill idle.
    always_comb begin
        shifted = fill;
        if (SHIFT_MSB) shifted = {buff[NUM_BITS-2:0], IDLE_VAL};
        else           shifted = {IDLE_VAL, buff[NUM_BITS-1:1]};
    end

    // Line level comes only from registered state.
    always_comb begin
        serial_out = IDLE_VAL;
        if (state == SHIFT) begin
            if (SHIFT_MSB) serial_out = buff[NUM_BITS-1];
            else           serial_out = buff[0];
        end
    end

    // Main FSM: load, shift, reload from hold or the bus, return to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            buff      <= fill;
            hold      <= '0;
            hold_full <= 1'b0;
            cnt       <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        buff  <= ld.parallel_in;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (final_shift) begin
                        word_done <= 1'b1;
                        cnt       <= '0;
                        if (hold_full) begin
                            buff      <= hold;
                            hold_full <= 1'b0;
                        end else if (accept) begin
                            buff <= ld.parallel_in;
                        end else begin
                            buff  <= fill;
                            state <= IDLE;
                        end
                    end else begin
                        if (shift_enable) begin
                            buff <= shifted;
                            cnt  <= cnt + CW'(1);
                        end
                        if (accept) begin
                            hold      <= ld.parallel_in;
                            hold_full <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_flex_pts_tx.sv
// tb_flex_pts_tx: scoreboard bench for flex_pts_tx; an MSB-first idle-high
// instance and an LSB-first idle-low instance.
module tb_flex_pts_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic shift_enable = 1'b0;
    logic serial_out, busy, word_done;
    logic se1 = 1'b0;
    logic serial1, busy1, done1;

    int n_run  = 0;
    int n_fail = 0;
    int popped = 0;
    bit exp_done = 1'b0;
    bit exp_q[$];
    bit q1[$];

    flex_pts_tx_if #(.NUM_BITS(8)) bus0 ();
    flex_pts_tx_if #(.NUM_BITS(8)) bus1 ();

    flex_pts_tx #(.NUM_BITS(8), .SHIFT_MSB(1'b1), .IDLE_VAL(1'b1)) dut (
        .clk(clk), .rst(rst), .shift_enable(shift_enable), .ld(bus0),
        .serial_out(serial_out), .busy(busy), .word_done(word_done)
    );

    flex_pts_tx #(.NUM_BITS(8), .SHIFT_MSB(1'b0), .IDLE_VAL(1'b0)) dut1 (
        .clk(clk), .rst(rst), .shift_enable(se1), .ld(bus1),
        .serial_out(serial1), .busy(busy1), .word_done(done1)
    );

    always #5 clk = ~clk;

    function automatic bit exp_ser();
        return (exp_q.size() > 0) ? exp_q[0] : 1'b1;
    endfunction

    function automatic bit exp_busy();
        return exp_q.size() > 0;
    endfunction

    function automatic bit exp_rdy();
        return exp_q.size() <= 8;
    endfunction

    // Drive one cycle on dut and advance the scoreboard; no checking here.
    task automatic tick(input bit r, input bit se, input bit lv, input logic [7:0] d);
        bit strobe, acc;
        rst = r; shift_enable = se;
        bus0.load_valid = lv; bus0.parallel_in = d;
        strobe = !r && se && (exp_q.size() > 0);
        acc    = !r && lv && (exp_q.size() <= 8);
        @(posedge clk);
        exp_done = 1'b0;
        if (r) begin
            exp_q.delete();
            popped = 0;
        end else begin
            if (strobe) begin
                void'(exp_q.pop_front());
                popped++;
                if (popped == 8) begin
                    exp_done = 1'b1;
                    popped = 0;
                end
            end
            if (acc) for (int i = 7; i >= 0; i--) exp_q.push_back(d[i]);
        end
        #1;
    endtask

    task automatic test_reset();
        bus1.load_valid = 1'b0; bus1.parallel_in = '0;
        tick(1, 0, 0, 8'h00);
        tick(1, 1, 1, 8'hFF);
        n_run++; if (serial_out !== 1'b1) begin n_fail++; $display("FAIL reset serial got %b want 1", serial_out); end
        n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got %b want 0", busy); end
        n_run++; if (bus0.load_ready !== 1'b1) begin n_fail++; $display("FAIL reset ready got %b want 1", bus0.load_ready); end
        n_run++; if (word_done !== 1'b0) begin n_fail++; $display("FAIL reset done got %b want 0", word_done); end
        n_run++; if (serial1 !== 1'b0) begin n_fail++; $display("FAIL reset serial1 got %b want 0", serial1); end
        tick(0, 0, 0, 8'h00);
    endtask

    task automatic test_lsb_first();
        int nd = 0;
        bus1.load_valid = 1'b1; bus1.parallel_in = 8'h0F; se1 = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 8; i++) q1.push_back(bus1.parallel_in[i]);
        #1;
        bus1.load_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            n_run++; if (serial1 !== ((q1.size() > 0) ? q1[0] : 1'b0)) begin n_fail++; $display("FAIL lsb serial cyc %0d got %b want %b", c, serial1, (q1.size() > 0) ? q1[0] : 1'b0); end
            n_run++; if (busy1 !== (q1.size() > 0)) begin n_fail++; $display("FAIL lsb busy cyc %0d got %b want %b", c, busy1, q1.size() > 0); end
            se1 = (c % 2 == 1);
            @(posedge clk);
            if (se1 && q1.size() > 0) void'(q1.pop_front());
            #1;
            if (done1) nd++;
        end
        se1 = 1'b0;
        n_run++; if (nd !== 1) begin n_fail++; $display("FAIL lsb done_count got %0d want 1", nd); end
    endtask

    task automatic test_single();
        int nd = 0;
        tick(0, 0, 1, 8'hA5);
        for (int c = 0; c < 36; c++) begin
            n_run++; if (serial_out !== exp_ser()) begin n_fail++; $display("FAIL single serial cyc %0d got %b want %b", c, serial_out, exp_ser()); end
            n_run++; if (busy !== exp_busy()) begin n_fail++; $display("FAIL single busy cyc %0d got %b want %b", c, busy, exp_busy()); end
            n_run++; if (word_done !== exp_done) begin n_fail++; $display("FAIL single done cyc %0d got %b want %b", c, word_done, exp_done); end
            if (word_done) nd++;
            tick(0, (c % 4 == 3), 0, 8'h00);
        end
        n_run++; if (nd !== 1) begin n_fail++; $display("FAIL single done_count got %0d want 1", nd); end
    endtask

    task automatic test_back_to_back();
        int nd = 0;
        int nb = 0;
        tick(0, 1, 1, 8'hA5);
        for (int c = 0; c < 20; c++) begin
            n_run++; if (serial_out !== exp_ser()) begin n_fail++; $display("FAIL b2b serial cyc %0d got %b want %b", c, serial_out, exp_ser()); end
            n_run++; if (busy !== exp_busy()) begin n_fail++; $display("FAIL b2b busy cyc %0d got %b want %b", c, busy, exp_busy()); end
            n_run++; if (bus0.load_ready !== exp_rdy()) begin n_fail++; $display("FAIL b2b ready cyc %0d got %b want %b", c, bus0.load_ready, exp_rdy()); end
            n_run++; if (word_done !== exp_done) begin n_fail++; $display("FAIL b2b done cyc %0d got %b want %b", c, word_done, exp_done); end
            if (word_done) nd++;
            if (busy) nb++;
            tick(0, 1, (c == 1) || (c == 3), (c == 1) ? 8'h3C : 8'hEE);
        end
        n_run++; if (nd !== 2) begin n_fail++; $display("FAIL b2b done_count got %0d want 2", nd); end
        n_run++; if (nb !== 16) begin n_fail++; $display("FAIL b2b busy_cycles got %0d want 16", nb); end
    endtask

    task automatic test_direct_accept();
        int nd = 0;
        tick(0, 0, 1, 8'hFF);
        for (int c = 0; c < 20; c++) begin
            n_run++; if (serial_out !== exp_ser()) begin n_fail++; $display("FAIL direct serial cyc %0d got %b want %b", c, serial_out, exp_ser()); end
            n_run++; if (busy !== exp_busy()) begin n_fail++; $display("FAIL direct busy cyc %0d got %b want %b", c, busy, exp_busy()); end
            n_run++; if (bus0.load_ready !== 1'b1) begin n_fail++; $display("FAIL direct ready cyc %0d got %b want 1", c, bus0.load_ready); end
            n_run++; if (word_done !== exp_done) begin n_fail++; $display("FAIL direct done cyc %0d got %b want %b", c, word_done, exp_done); end
            if (word_done) nd++;
            tick(0, 1, (c == 7), 8'h81);
        end
        n_run++; if (nd !== 2) begin n_fail++; $display("FAIL direct done_count got %0d want 2", nd); end
    endtask

    task automatic test_reset_mid();
        tick(0, 0, 1, 8'hA5);
        tick(0, 1, 0, 8'h00);
        tick(0, 1, 1, 8'h3C);
        tick(0, 1, 0, 8'h00);
        n_run++; if (bus0.load_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid held_ready got %b want 0", bus0.load_ready); end
        tick(1, 1, 0, 8'h00);
        n_run++; if (serial_out !== 1'b1) begin n_fail++; $display("FAIL rstmid serial got %b want 1", serial_out); end
        n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid busy got %b want 0", busy); end
        n_run++; if (bus0.load_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid ready got %b want 1", bus0.load_ready); end
        n_run++; if (word_done !== 1'b0) begin n_fail++; $display("FAIL rstmid done got %b want 0", word_done); end
        tick(0, 0, 1, 8'h5A);
        for (int c = 0; c < 12; c++) begin
            n_run++; if (serial_out !== exp_ser()) begin n_fail++; $display("FAIL rstmid serial cyc %0d got %b want %b", c, serial_out, exp_ser()); end
            n_run++; if (busy !== exp_busy()) begin n_fail++; $display("FAIL rstmid busy cyc %0d got %b want %b", c, busy, exp_busy()); end
            n_run++; if (word_done !== exp_done) begin n_fail++; $display("FAIL rstmid done cyc %0d got %b want %b", c, word_done, exp_done); end
            tick(0, 1, 0, 8'h00);
        end
    endtask

    task automatic test_idle_strobe();
        for (int c = 0; c < 6; c++) begin
            tick(0, (c % 2 == 0), 0, 8'h00);
            n_run++; if (serial_out !== exp_ser() || busy !== exp_busy()) begin n_fail++; $display("FAIL idle serial/busy cyc %0d got %b/%b want %b/%b", c, serial_out, busy, exp_ser(), exp_busy()); end
        end
        tick(0, 1, 1, 8'hC3);
        for (int c = 0; c < 12; c++) begin
            n_run++; if (serial_out !== exp_ser()) begin n_fail++; $display("FAIL idlestb serial cyc %0d got %b want %b", c, serial_out, exp_ser()); end
            n_run++; if (busy !== exp_busy()) begin n_fail++; $display("FAIL idlestb busy cyc %0d got %b want %b", c, busy, exp_busy()); end
            n_run++; if (word_done !== exp_done) begin n_fail++; $display("FAIL idlestb done cyc %0d got %b want %b", c, word_done, exp_done); end
            tick(0, 1, 0, 8'h00);
        end
    endtask

    initial begin
        bus0.load_valid = 1'b0;
        bus0.parallel_in = '0;
        #1;
        test_reset();
        test_lsb_first();
        test_single();
        test_back_to_back();
        test_direct_accept();
        test_reset_mid();
        test_idle_strobe();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/flex_pts_tx.md
# flex_pts_tx

Parametrised parallel-to-serial transmitter with a one-word holding buffer and a ready/valid load handshake. It is the next generation of the team's flexible parallel-to-serial shift register and adds a per-word bit counter, a word-complete pulse, a busy flag and a configurable idle line level. Back-to-back words stream with no gap between the last bit of one word and the first bit of the next. It sits between a word producer (FIFO or controller) and a serial line whose bit rate comes from an external `shift_enable` strobe (timer/divider).

## Interface
- `NUM_BITS`, 8: word width; legal values are 2 and above.
- `SHIFT_MSB`, 1: 1 sends the MSB first; 0 sends the LSB first.
- `IDLE_VAL`, 1: line level when no word is in flight; also the fill bit shifted in behind the data.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `shift_enable`  in  1  bit strobe; advances one bit per cycle in which it is high.
- `load_valid`  in  1  producer has a word on `parallel_in`.
- `parallel_in`  in  NUM_BITS  word to transmit.
- `load_ready`  out  1  block can accept a word this cycle; equals `!hold_full`, combinational from registers.
- `serial_out`  out  1  serial line.
- `busy`  out  1  a word is currently shifting (state SHIFT).
- `word_done`  out  1  registered pulse, one cycle, after the final bit of a word has shifted.

## Operation
- Internal state:
  - shift register `buff[NUM_BITS-1:0]`
  - bit counter `cnt`, clog2(NUM_BITS) bits, counts 0..NUM_BITS-1 and never wraps past NUM_BITS-1
  - holding register `hold` with flag `hold_full`
  - FSM with states IDLE and SHIFT
- A word is accepted when `load_valid && load_ready` at a rising edge.
- `serial_out` is `IDLE_VAL` in IDLE. In SHIFT it is `buff[NUM_BITS-1]` when `SHIFT_MSB`=1 and `buff[0]` otherwise. It is a registered-state function with no combinational path from inputs.
- Each shift moves `buff` toward the output end and fills the vacated bit with `IDLE_VAL`.
- IDLE:
  - On accept: `buff<=parallel_in`, `cnt<=0`, go to SHIFT. `hold` is untouched.
  - `shift_enable` is ignored, including in the accept cycle.
- SHIFT, `shift_enable`=1 and `cnt`<NUM_BITS-1: shift, `cnt++`.
- SHIFT, `shift_enable`=1 and `cnt`==NUM_BITS-1 (final shift): `word_done<=1`, then the first matching rule applies:
  - `hold_full`: `buff<=hold`, `hold_full<=0`, `cnt<=0`, stay in SHIFT.
  - Accept this cycle (hold empty): `buff<=parallel_in`, `cnt<=0`, stay in SHIFT. `hold` is not written.
  - Otherwise: `buff` is filled with `IDLE_VAL`, `cnt<=0`, go to IDLE.
- SHIFT, accept when not on the final shift: `hold<=parallel_in`, `hold_full<=1`. A shift in the same cycle proceeds normally.
- With `hold_full`=1, `load_ready`=0, so `load_valid` is ignored. `load_ready` returns to 1 the cycle after the final shift empties `hold`.
- `busy` = (state==SHIFT). `word_done` is 0 in every cycle not described above.
- Reset state, applied at the edge where `rst` is high and overriding all other inputs, including mid-word:
  - state IDLE, `buff` all `IDLE_VAL`, `hold` 0, `hold_full` 0, `cnt` 0, `word_done` 0
  - both in-flight words are discarded
  - outputs: `serial_out`=`IDLE_VAL`, `load_ready`=1, `busy`=0

## Timing
- Load latency: accept at edge k; the first data bit appears on `serial_out` and `busy`=1 after edge k.
- Bit i (0-based) is on the line from the edge of the i-th `shift_enable` after load until the next strobe.
- `word_done` is high for exactly the cycle after the edge of the final (NUM_BITS-th) strobe.
- Back-to-back words: the next word's first bit appears at that same edge, so there are no idle cycles and `busy` stays 1.
- End of stream with no next word: `serial_out` returns to `IDLE_VAL` and `busy`=0 after the final-strobe edge.
- Throughput: one word per NUM_BITS strobes; `shift_enable` may be high every cycle.

## Test plan
- NUM_BITS=8, SHIFT_MSB=1, IDLE_VAL=1; load 0xA5 from IDLE, strobe every 4 cycles -> `serial_out` 1,0,1,0,0,1,0,1 then 1; one `word_done` pulse; `busy` falls at the 8th strobe edge.
- Same configuration; load 0xA5, then 0x3C two cycles later, strobe every cycle -> 16 contiguous bits 10100101 00111100; `load_ready` low from the 0x3C accept until the cycle after the 8th strobe; two `word_done` pulses 8 cycles apart; `busy` stays 1 throughout.
- SHIFT_MSB=0, IDLE_VAL=0; load 0x0F -> `serial_out` 1,1,1,1,0,0,0,0 then 0.
- Hold empty; present 0x81 with `load_valid` in the cycle of the final strobe of 0xFF -> accepted directly with no gap: 11111111 10000001; `hold_full` never set.
- `rst` asserted after 3 bits of 0xA5, with 0x3C held -> next cycle `serial_out`=`IDLE_VAL`, `busy`=0, `load_ready`=1, no `word_done`; a fresh 0x5A load then transmits correctly.
- `shift_enable` toggling in IDLE, and high on the accept edge -> no bit consumed; the full 8-bit word is sent after load.
